nf5_core: RTL and testbench
===========================

// Module: nf5_core
// PURPOSE
//  RV32I integer core: 2-cycle multi-cycle FSM with a private unified instruction/data memory.
//  It is the top of the NF5 processor subsystem.
//  It fetches instructions from address 0 and executes them.
//  Results go to the register file and to memory; benches read compliance signatures straight from the memory array.
// PARAMETERS
//  MEM_WORDS  4096  depth of 32-bit unified memory (16 KiB), word index = addr[13:2]
//  RESET_PC   0     PC value loaded on reset
// PORTS
//  clk     in   1   single clock, all state on rising edge
//  rst_n   in   1   reset: asynchronous, active-high (asserted when 1)
//  pc_o    out  32  current PC
//  halt_o  out  1   1 once ECALL/EBREAK executed
// BEHAVIOUR
//  - Memory: reg [31:0] dmem [0:MEM_WORDS-1].
//    - Little-endian: byte lane k = dmem[i][8k+:8].
//    - Combinational read, synchronous write.
//    - Not cleared by reset; preloaded hierarchically.
//    - Addresses wrap: only addr[13:2] is used.
//  - Reset (async): pc=RESET_PC, x1..x31=0, state=FETCH, halt_o=0.
//    - An in-flight store is not committed while reset is asserted.
//  - FSM, 2 cycles per instruction:
//    - FETCH: ir <= dmem[pc[13:2]]; go to EXEC.
//    - EXEC: decode/ALU; write rd (except x0); perform store; pc <= next_pc; go to FETCH.
//  - x0 always reads 0; writes to it are discarded.
//  - Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW,
//    ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
//  - Arithmetic: 32-bit wrap, no traps. Shift amount = low 5 bits. SLT signed, SLTU unsigned.
//  - Immediates: I/S/B/J sign-extended; U = imm<<12.
//  - Branch/JAL target = pc+imm. JALR target = (rs1+imm)&~1. Link = pc+4.
//  - Byte/halfword access:
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//    - Halfword uses addr[1] (addr[0] ignored); word ignores addr[1:0]; byte uses addr[1:0].
//    - Stores write only the selected lanes (byte enables); other lanes are unchanged.
//  - FENCE and unknown opcodes: NOP, pc+4.
//  - ECALL/EBREAK: halt_o<=1; pc held; FSM idles in FETCH without further execution until reset.
//  - Regfile read in EXEC sees the values written by the prior instruction (no hazards; sequential).
//  - Target throughput: ≥350 instructions within 750 cycles.
// TESTING
//  1 ALU/store: LUI x3,0x2; ADDI x1,x0,5; ADDI x2,x1,-7; SW x2,0(x3)
//    -> dmem[0x800]=0xFFFFFFFE after 8 cycles.
//  2 Byte lanes: dmem[0x800]=0; ADDI x4,x0,0x80; SB x4,1(x3); LB x5,1(x3); LBU x6,1(x3); SW x5,4(x3); SW x6,8(x3)
//    -> dmem[0x800]=0x00008000, dmem[0x801]=0xFFFFFF80, dmem[0x802]=0x00000080.
//  3 Loop: x1=0, x2=10; ADDI x1,x1,1; BNE x1,x2,-4; SW x1,0(x3)
//    -> dmem[0x800]=10; ADD/SUB checks 0x7FFFFFFF+1=0x80000000; SRA 0x80000000>>4=0xF8000000.
//  4 Jumps: JAL x1,+8 at pc 0x10 -> x1=0x14, pc=0x18. JALR x2,3(x0) -> pc=0x2, x2=link.
//    Store both links and check.
//  5 x0/halt: ADDI x0,x0,7; SW x0,0(x3); ECALL
//    -> dmem[0x800]=0, halt_o=1, pc_o constant for 20 cycles, no further stores.
//  6 Reset mid-run: assert rst_n=1 between clock edges during loop
//    -> pc_o=0, regs 0, halt_o=0 immediately; release -> program re-executes; memory retained.

Source files
------------

// File: rtl/nf5_core.sv
// NF5 RV32I core: two-cycle fetch/execute FSM over a private unified memory.
// The memory is word-indexed by addr[AW+1:2] and is preloaded from outside.
module nf5_core #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  output logic        halt_o
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t        state, state_next;
  logic [31:0]   dmem [0:MEM_WORDS-1];
  logic [31:0]   regs [1:31];
  logic [31:0]   pc, ir;
  logic          halt;

  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    f3;
  logic [31:0]   rs1_val, rs2_val;
  logic [31:0]   imm_i, imm_b, imm_u, imm_j;
  logic [11:0]   imm_mem;
  logic [AW+1:0] mem_addr;
  logic [31:0]   mem_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   alu_b, alu_y;
  logic          alu_alt, taken;
  logic [31:0]   next_pc, wr_data, st_data;
  logic          wr_en, do_halt;
  logic [3:0]    st_be;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign f3      = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u   = {ir[31:12], 12'h000};
  assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Only the low address bits matter because the memory wraps.
  assign imm_mem  = (opcode == 7'h23) ? {ir[31:25], ir[11:7]} : ir[31:20];
  assign mem_addr = rs1_val[AW+1:0] + (AW+2)'($signed(imm_mem));
  assign mem_word = dmem[mem_addr[AW+1:2]];
  assign ld_byte  = mem_word[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half  = mem_addr[1] ? mem_word[31:16] : mem_word[15:0];

  assign alu_b   = (opcode == 7'h33) ? rs2_val : imm_i;
  assign alu_alt = ir[30] && ((opcode == 7'h33) || (f3 == 3'd5));

  always_comb begin
    alu_y = 32'h0;
    case (f3)
      3'd0: alu_y = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_y = rs1_val << alu_b[4:0];
      3'd2: alu_y = {31'h0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_y = {31'h0, rs1_val < alu_b};
      3'd4: alu_y = rs1_val ^ alu_b;
      3'd5: alu_y = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'd6: alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = (rs1_val == rs2_val);
      3'd1: taken = (rs1_val != rs2_val);
      3'd4: taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6: taken = (rs1_val < rs2_val);
      3'd7: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Next state plus all EXEC-phase side effects for the current instruction.
  always_comb begin
    state_next = state;
    next_pc    = pc + 32'd4;
    wr_en      = 1'b0;
    wr_data    = 32'h0;
    st_data    = 32'h0;
    st_be      = 4'b0000;
    do_halt    = 1'b0;
    case (state)
      FETCH: if (!halt) state_next = EXEC;
      default: begin
        state_next = FETCH;
        case (opcode)
          7'h37: begin wr_en = 1'b1; wr_data = imm_u; end
          7'h17: begin wr_en = 1'b1; wr_data = pc + imm_u; end
          7'h6f: begin wr_en = 1'b1; wr_data = pc + 32'd4; next_pc = pc + imm_j; end
          7'h67: begin
            wr_en   = 1'b1;
            wr_data = pc + 32'd4;
            next_pc = (rs1_val + imm_i) & ~32'd1;
          end
          7'h63: if (taken) next_pc = pc + imm_b;
          7'h03: begin
            wr_en = 1'b1;
            case (f3)
              3'd0: wr_data = {{24{ld_byte[7]}}, ld_byte};
              3'd1: wr_data = {{16{ld_half[15]}}, ld_half};
              3'd2: wr_data = mem_word;
              3'd4: wr_data = {24'h0, ld_byte};
              3'd5: wr_data = {16'h0, ld_half};
              default: wr_en = 1'b0;
            endcase
          end
          7'h23: begin
            case (f3)
              3'd0: begin st_data = {4{rs2_val[7:0]}}; st_be = 4'b0001 << mem_addr[1:0]; end
              3'd1: begin st_data = {2{rs2_val[15:0]}}; st_be = mem_addr[1] ? 4'b1100 : 4'b0011; end
              3'd2: begin st_data = rs2_val; st_be = 4'b1111; end
              default: st_be = 4'b0000;
            endcase
          end
          7'h13, 7'h33: begin wr_en = 1'b1; wr_data = alu_y; end
          7'h73: if (f3 == 3'd0) begin do_halt = 1'b1; next_pc = pc; end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      halt  <= 1'b0;
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      state <= state_next;
      if (state == FETCH) begin
        if (!halt) ir <= dmem[pc[AW+1:2]];
      end else begin
        if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
        pc <= next_pc;
        if (do_halt) halt <= 1'b1;
      end
    end
  end

  // Memory has no reset; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n && state == EXEC) begin
      for (int k = 0; k < 4; k++)
        if (st_be[k]) dmem[mem_addr[AW+1:2]][8*k +: 8] <= st_data[8*k +: 8];
    end
  end

  assign pc_o   = pc;
  assign halt_o = halt;
endmodule

// File: tb/tb_nf5_core.sv
// Bench for nf5_core: directed programs plus randomized ALU and byte-lane
// programs, checked against plain-arithmetic expectations.
module tb_nf5_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_o;
  logic        halt_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] prog[$];

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam int SIG = 32'h800;

  nf5_core dut (.clk(clk), .rst_n(rst_n), .pc_o(pc_o), .halt_o(halt_o));

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] r1, logic [31:0] f3, logic [31:0] rd, logic [6:0] op);
    return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(logic alt, logic [31:0] r2, logic [31:0] r1, logic [31:0] f3, logic [31:0] rd);
    return {1'b0, alt, 5'b0, r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] r2, logic [31:0] r1, logic [31:0] f3);
    return {imm[11:5], r2[4:0], r1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] r2, logic [31:0] r1, logic [31:0] f3);
    return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm20, logic [31:0] rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic emit_li(input int rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = (v + 32'h800) >> 12;
    prog.push_back(enc_u(hi, rd, 7'h37));
    prog.push_back(enc_i({20'h0, v[11:0]}, rd, 0, rd, 7'h13));
  endtask

  // Holds the core in reset and copies the program to address 0.
  task automatic load_program();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) dut.dmem[i] = ECALL;
    foreach (prog[i]) dut.dmem[i] = prog[i];
  endtask

  task automatic wait_halt(input string tag);
    int cyc;
    cyc = 0;
    while (!halt_o && cyc < 800) begin
      @(negedge clk);
      cyc++;
    end
    check_output({tag, "_halt"}, {31'h0, halt_o}, 32'h1);
  endtask

  task automatic run_program(input string tag);
    load_program();
    @(negedge clk) rst_n = 1'b0;
    wait_halt(tag);
  endtask

  function automatic logic [31:0] ref_op(int k, logic [31:0] a, logic [31:0] b);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return 32'($signed(a) >>> b[4:0]);
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  initial begin
    int r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int i_ops[9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
    logic [31:0] a, b, w, v, exp_w, exp_s, exp_u, held_pc;
    logic [7:0] mb[4];
    int k, sz, off, base, moves;
    logic is_imm;

    for (int i = 0; i < 4096; i++) dut.dmem[i] = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset_pc", pc_o, 32'h0);
    check_output("reset_halt", {31'h0, halt_o}, 32'h0);

    // Test 1: ALU and store, result visible after 8 cycles.
    prog.delete();
    prog.push_back(enc_u(2, 3, 7'h37));
    prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
    prog.push_back(enc_i(-7, 1, 0, 2, 7'h13));
    prog.push_back(enc_s(0, 2, 3, 2));
    load_program();
    dut.dmem[SIG] = 32'h0;
    @(negedge clk) rst_n = 1'b0;
    repeat (8) @(negedge clk);
    check_output("t1_sw", dut.dmem[SIG], 32'hFFFF_FFFE);
    wait_halt("t1");

    // Test 2: byte lanes.
    prog.delete();
    prog.push_back(enc_u(2, 3, 7'h37));
    prog.push_back(enc_i(32'h80, 0, 0, 4, 7'h13));
    prog.push_back(enc_s(1, 4, 3, 0));
    prog.push_back(enc_i(1, 3, 0, 5, 7'h03));
    prog.push_back(enc_i(1, 3, 4, 6, 7'h03));
    prog.push_back(enc_s(4, 5, 3, 2));
    prog.push_back(enc_s(8, 6, 3, 2));
    dut.dmem[SIG] = 32'h0;
    run_program("t2");
    check_output("t2_sb", dut.dmem[SIG], 32'h0000_8000);
    check_output("t2_lb", dut.dmem[SIG+1], 32'hFFFF_FF80);
    check_output("t2_lbu", dut.dmem[SIG+2], 32'h0000_0080);

    // Test 3: loop plus overflow, SUB and SRA corners.
    prog.delete();
    prog.push_back(enc_u(2, 3, 7'h37));
    prog.push_back(enc_i(10, 0, 0, 2, 7'h13));
    prog.push_back(enc_i(1, 1, 0, 1, 7'h13));
    prog.push_back(enc_b(-4, 2, 1, 1));
    prog.push_back(enc_s(0, 1, 3, 2));
    emit_li(7, 32'h7FFF_FFFF);
    prog.push_back(enc_i(1, 0, 0, 8, 7'h13));
    prog.push_back(enc_r(1'b0, 8, 7, 0, 9));
    prog.push_back(enc_s(4, 9, 3, 2));
    prog.push_back(enc_u(32'h80000, 10, 7'h37));
    prog.push_back(enc_i(4, 0, 0, 11, 7'h13));
    prog.push_back(enc_r(1'b1, 11, 10, 5, 12));
    prog.push_back(enc_s(8, 12, 3, 2));
    prog.push_back(enc_r(1'b1, 8, 9, 0, 13));
    prog.push_back(enc_s(12, 13, 3, 2));
    for (int i = 0; i < 4; i++) dut.dmem[SIG+i] = 32'h0;
    run_program("t3");
    check_output("t3_loop", dut.dmem[SIG], 32'd10);
    check_output("t3_add", dut.dmem[SIG+1], 32'h8000_0000);
    check_output("t3_sra", dut.dmem[SIG+2], 32'hF800_0000);
    check_output("t3_sub", dut.dmem[SIG+3], 32'h7FFF_FFFF);

    // Test 6: reset asserted mid-loop between clock edges.
    load_program();
    dut.dmem[SIG] = 32'h0;
    @(negedge clk) rst_n = 1'b0;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_output("t6_pc", pc_o, 32'h0);
    check_output("t6_halt", {31'h0, halt_o}, 32'h0);
    check_output("t6_x1", dut.regs[1], 32'h0);
    check_output("t6_mem", dut.dmem[2], prog[2]);
    @(negedge clk) rst_n = 1'b0;
    wait_halt("t6");
    check_output("t6_rerun", dut.dmem[SIG], 32'd10);

    // Test 4: JAL and JALR with an odd target.
    prog.delete();
    prog.push_back(enc_u(2, 3, 7'h37));
    repeat (3) prog.push_back(enc_i(0, 0, 0, 0, 7'h13));
    prog.push_back(enc_j(8, 1));
    prog.push_back(ECALL);
    prog.push_back(enc_s(0, 1, 3, 2));
    prog.push_back(enc_i(32'h29, 0, 0, 2, 7'h67));
    prog.push_back(ECALL);
    prog.push_back(ECALL);
    prog.push_back(enc_s(4, 2, 3, 2));
    load_program();
    @(negedge clk) rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 check_output("t4_jal_pc", pc_o, 32'h18);
    wait_halt("t4");
    check_output("t4_jal_link", dut.dmem[SIG], 32'h14);
    check_output("t4_jalr_link", dut.dmem[SIG+1], 32'h20);
    check_output("t4_halt_pc", pc_o, 32'h2C);

    // Test 5: x0 stays zero; nothing executes after ECALL.
    prog.delete();
    prog.push_back(enc_u(2, 3, 7'h37));
    prog.push_back(enc_i(7, 0, 0, 0, 7'h13));
    prog.push_back(enc_s(0, 0, 3, 2));
    prog.push_back(ECALL);
    prog.push_back(enc_s(4, 3, 3, 2));
    dut.dmem[SIG] = 32'hDEAD_BEEF;
    dut.dmem[SIG+1] = 32'h1234_5678;
    run_program("t5");
    held_pc = pc_o;
    moves = 0;
    repeat (20) begin
      @(negedge clk);
      if (pc_o !== held_pc || halt_o !== 1'b1) moves++;
    end
    check_output("t5_pc", held_pc, 32'hC);
    check_output("t5_stable", moves, 0);
    check_output("t5_x0", dut.dmem[SIG], 32'h0);
    check_output("t5_nostore", dut.dmem[SIG+1], 32'h1234_5678);

    // Randomized ALU programs.
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      is_imm = $urandom_range(0, 1) == 1;
      prog.delete();
      emit_li(1, a);
      if (is_imm) begin
        k = i_ops[$urandom_range(0, 8)];
        if (k == 2 || k == 6 || k == 7) b = $urandom_range(0, 31);
        else b = {{20{1'b0}}, 12'($urandom)};
        b = {{20{b[11]}}, b[11:0]};
        prog.push_back(enc_i((k == 7) ? (b | 32'h400) : b, 1, r_f3[k], 5, 7'h13));
      end else begin
        k = $urandom_range(0, 9);
        b = $urandom;
        emit_li(2, b);
        prog.push_back(enc_r(k == 1 || k == 7, 2, 1, r_f3[k], 5));
      end
      prog.push_back(enc_u(2, 3, 7'h37));
      prog.push_back(enc_s(0, 5, 3, 2));
      dut.dmem[SIG] = 32'hA5A5_A5A5;
      run_program($sformatf("alu%0d", t));
      check_output($sformatf("alu%0d_op%0d_imm%0d", t, k, is_imm), dut.dmem[SIG], ref_op(k, a, b));
    end

    // Randomized sub-word stores and loads against a byte-array memory model.
    for (int t = 0; t < 12; t++) begin
      w = $urandom;
      v = $urandom;
      sz = $urandom_range(0, 2);
      off = $urandom_range(0, 3);
      base = off & 2;
      for (int j = 0; j < 4; j++) mb[j] = w[8*j +: 8];
      if (sz == 0) mb[off] = v[7:0];
      else if (sz == 1) begin mb[base] = v[7:0]; mb[base+1] = v[15:8]; end
      else for (int j = 0; j < 4; j++) mb[j] = v[8*j +: 8];
      exp_w = {mb[3], mb[2], mb[1], mb[0]};
      if (sz == 0) begin
        exp_s = {{24{mb[off][7]}}, mb[off]};
        exp_u = {24'h0, mb[off]};
      end else if (sz == 1) begin
        exp_s = {{16{mb[base+1][7]}}, mb[base+1], mb[base]};
        exp_u = {16'h0, mb[base+1], mb[base]};
      end else begin
        exp_s = exp_w;
        exp_u = exp_w;
      end
      prog.delete();
      emit_li(4, v);
      prog.push_back(enc_u(2, 3, 7'h37));
      prog.push_back(enc_s(off, 4, 3, sz));
      prog.push_back(enc_i(off, 3, sz, 5, 7'h03));
      prog.push_back(enc_i(off, 3, (sz == 2) ? 2 : sz + 4, 6, 7'h03));
      prog.push_back(enc_s(4, 5, 3, 2));
      prog.push_back(enc_s(8, 6, 3, 2));
      dut.dmem[SIG] = w;
      run_program($sformatf("mem%0d", t));
      check_output($sformatf("mem%0d_sz%0d_off%0d_word", t, sz, off), dut.dmem[SIG], exp_w);
      check_output($sformatf("mem%0d_signed", t), dut.dmem[SIG+1], exp_s);
      check_output($sformatf("mem%0d_unsigned", t), dut.dmem[SIG+2], exp_u);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
